// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the UART baud-rate clock generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_baud_pkg;

  localparam int DIV_W   = 16;
  // Smallest ratio that still yields a square wave (one low, one high cycle).
  localparam int MIN_DIV = 2;

  typedef logic [DIV_W-1:0] baud_div_t;

endpackage

// File: rtl/uart_baud_clkgen.sv
// Programmable integer divider: i_clk / cfg_div_ratio -> registered square-wave o_baud_clk.
// Latency: new ratio applies from the next edge; output phase tracks the counter on the same edge.
// Backpressure: none (free-running); optional o_baud_tick pulse when UART_BAUD_TICK_EN is defined.
module uart_baud_clkgen #(
  parameter int DIV_W = uart_baud_pkg::DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DIV_W-1:0] cfg_div_ratio,
  output logic             o_baud_clk
`ifdef UART_BAUD_TICK_EN
  ,
  output logic             o_baud_tick
`endif
);

  import uart_baud_pkg::*;

  logic             div_en;
  logic [DIV_W-1:0] n_eff;
  logic [DIV_W-1:0] low_len;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic             baud_next;

  // Effective ratio, phase split and next counter/output values.
  // The >= wrap compare lets a shrinking ratio fold the counter back to 0
  // immediately instead of running out to 2^DIV_W.
  always_comb begin
    div_en    = |cfg_div_ratio;
    n_eff     = (cfg_div_ratio == DIV_W'(1)) ? DIV_W'(MIN_DIV) : cfg_div_ratio;
    low_len   = n_eff >> 1;
    cnt_next  = '0;
    if (div_en && (cnt < (n_eff - DIV_W'(1)))) begin
      cnt_next = cnt + DIV_W'(1);
    end
    baud_next = div_en && (cnt_next >= low_len);
  end

  // Counter and output flop updated together so the output never lags the count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt        <= '0;
      o_baud_clk <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      o_baud_clk <= baud_next;
    end
  end

`ifdef UART_BAUD_TICK_EN
  // One-cycle strobe on each counter wrap, i.e. on every falling edge of o_baud_clk.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_baud_tick <= 1'b0;
    end else begin
      o_baud_tick <= div_en && (cnt_next == '0);
    end
  end
`endif

endmodule

// File: tb/tb_uart_baud_clkgen.sv
// Directed bench for uart_baud_clkgen: reset, steady ratios, disable, ratio changes, tick.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a; tick checks run only when UART_BAUD_TICK_EN is defined.
module tb_uart_baud_clkgen;

  import uart_baud_pkg::*;

  logic      i_clk;
  logic      i_rst;
  baud_div_t cfg_div_ratio;
  logic      o_baud_clk;
`ifdef UART_BAUD_TICK_EN
  logic      o_baud_tick;
`endif

  int n_checks;
  int n_fail;

  uart_baud_clkgen #(.DIV_W(DIV_W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .cfg_div_ratio (cfg_div_ratio),
    .o_baud_clk    (o_baud_clk)
`ifdef UART_BAUD_TICK_EN
    ,
    .o_baud_tick   (o_baud_tick)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Hold reset two cycles with ratio n, release between edges.
  task automatic do_reset(input baud_div_t n);
    @(negedge i_clk);
    i_rst         = 1'b0;
    cfg_div_ratio = n;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst         = 1'b0;
    cfg_div_ratio = 16'd6;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (o_baud_clk !== 1'b0) begin
        n_fail++; $display("FAIL reset_out cyc%0d got=%b exp=0", i, o_baud_clk);
      end
      n_checks++;
      if (dut.cnt !== 16'd0) begin
        n_fail++; $display("FAIL reset_cnt cyc%0d got=%0d exp=0", i, dut.cnt);
      end
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    // Run to the high phase (edge 4 -> cnt=4, out=1), then assert reset mid-cycle.
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (o_baud_clk !== 1'b1) begin
      n_fail++; $display("FAIL reset_prehigh got=%b exp=1", o_baud_clk);
    end
    #2;
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_baud_clk !== 1'b0) begin
      n_fail++; $display("FAIL reset_async got=%b exp=0", o_baud_clk);
    end
    n_checks++;
    if (dut.cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_async_cnt got=%0d exp=0", dut.cnt);
    end
  endtask

  task automatic test_div6();
    int rises, falls;
    logic prev, exp_o;
    rises = 0; falls = 0; prev = 1'b0;
    do_reset(16'd6);
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_o = ((k % 6) >= 3);
      n_checks++;
      if (o_baud_clk !== exp_o) begin
        n_fail++; $display("FAIL div6_edge%0d got=%b exp=%b", k, o_baud_clk, exp_o);
      end
      if (o_baud_clk && !prev) rises++;
      if (!o_baud_clk && prev) falls++;
      prev = o_baud_clk;
    end
    n_checks++;
    if (rises != 5 || falls != 5) begin
      n_fail++; $display("FAIL div6_periods rises=%0d falls=%0d exp=5/5", rises, falls);
    end
  endtask

  task automatic test_div5();
    logic [0:9] pat;
    pat = 10'b0111001110;
    do_reset(16'd5);
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (o_baud_clk !== pat[k]) begin
        n_fail++; $display("FAIL div5_edge%0d got=%b exp=%b", k + 1, o_baud_clk, pat[k]);
      end
    end
  endtask

  task automatic test_div1_div2();
    logic [0:7] pat;
    pat = 8'b10101010;
    do_reset(16'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (o_baud_clk !== pat[k]) begin
        n_fail++; $display("FAIL div1_edge%0d got=%b exp=%b", k + 1, o_baud_clk, pat[k]);
      end
    end
    do_reset(16'd2);
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (o_baud_clk !== pat[k]) begin
        n_fail++; $display("FAIL div2_edge%0d got=%b exp=%b", k + 1, o_baud_clk, pat[k]);
      end
    end
  endtask

  task automatic test_disable();
    logic [0:7] pat;
    int bad;
    pat = 8'b01100110;
    bad = 0;
    do_reset(16'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_baud_clk !== 1'b0 || dut.cnt !== 16'd0) bad++;
`ifdef UART_BAUD_TICK_EN
      if (o_baud_tick !== 1'b0) bad++;
`endif
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL div0_hold bad_cycles=%0d exp=0", bad);
    end
    @(negedge i_clk);
    cfg_div_ratio = 16'd4;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (o_baud_clk !== pat[k]) begin
        n_fail++; $display("FAIL div0to4_edge%0d got=%b exp=%b", k + 1, o_baud_clk, pat[k]);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [0:7] pat4;
    logic [0:6] pat8;
    pat4 = 8'b01100110;
    pat8 = 7'b0011110;
    do_reset(16'd10);
    for (int k = 0; k < 7; k++) step();
    n_checks++;
    if (dut.cnt !== 16'd7 || o_baud_clk !== 1'b1) begin
      n_fail++; $display("FAIL shrink_pre cnt=%0d out=%b exp=7/1", dut.cnt, o_baud_clk);
    end
    @(negedge i_clk);
    cfg_div_ratio = 16'd4;
    step();
    n_checks++;
    if (dut.cnt !== 16'd0 || o_baud_clk !== 1'b0) begin
      n_fail++; $display("FAIL shrink_wrap cnt=%0d out=%b exp=0/0", dut.cnt, o_baud_clk);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (o_baud_clk !== pat4[k]) begin
        n_fail++; $display("FAIL shrink4_edge%0d got=%b exp=%b", k + 1, o_baud_clk, pat4[k]);
      end
    end
    step();
    n_checks++;
    if (dut.cnt !== 16'd1 || o_baud_clk !== 1'b0) begin
      n_fail++; $display("FAIL grow_pre cnt=%0d out=%b exp=1/0", dut.cnt, o_baud_clk);
    end
    @(negedge i_clk);
    cfg_div_ratio = 16'd8;
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if (o_baud_clk !== pat8[k]) begin
        n_fail++; $display("FAIL grow8_edge%0d got=%b exp=%b", k + 1, o_baud_clk, pat8[k]);
      end
    end
  endtask

`ifdef UART_BAUD_TICK_EN
  task automatic test_tick();
    logic prev, exp_t;
    @(negedge i_clk);
    i_rst         = 1'b0;
    cfg_div_ratio = 16'd6;
    #1;
    n_checks++;
    if (o_baud_tick !== 1'b0) begin
      n_fail++; $display("FAIL tick_reset got=%b exp=0", o_baud_tick);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    prev = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      exp_t = ((k % 6) == 0);
      n_checks++;
      if (o_baud_tick !== exp_t) begin
        n_fail++; $display("FAIL tick_edge%0d got=%b exp=%b", k, o_baud_tick, exp_t);
      end
      n_checks++;
      if (o_baud_tick !== (prev && !o_baud_clk)) begin
        n_fail++; $display("FAIL tick_align%0d tick=%b clk=%b prevclk=%b", k, o_baud_tick, o_baud_clk, prev);
      end
      prev = o_baud_clk;
    end
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    i_rst         = 1'b0;
    cfg_div_ratio = '0;
    test_reset();
    test_div6();
    test_div5();
    test_div1_div2();
    test_disable();
    test_ratio_change();
`ifdef UART_BAUD_TICK_EN
    test_tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baud_clkgen.md
Name: uart_baud_clkgen

Overview:
- Programmable integer clock divider that produces the UART baud-rate clock from the system clock.
- Sits between the UART register block, which supplies cfg_div_ratio, and the TX/RX shift engines, which consume o_baud_clk.
- Output is a registered, glitch-free square wave with period cfg_div_ratio i_clk cycles.

Parameters:
- DIV_W, 16, width of cfg_div_ratio and the internal cycle counter.

Ports:
- i_clk  input  1  system clock; all logic is rising-edge.
- i_rst  input  1  reset, asynchronous, active-low: asserted when 0, deasserted synchronously to i_clk by the reset synchroniser upstream.
- cfg_div_ratio  input  DIV_W  divide ratio N, quasi-static; sampled every cycle.
- o_baud_clk  output  1  divided clock, driven directly from a flop.

Behaviour:
- Effective ratio N_eff:
  - N = 0: divider disabled.
  - N = 1: N_eff = 2 (minimum legal ratio).
  - Otherwise N_eff = N.
- Phase lengths: L = floor(N_eff/2) low cycles, H = N_eff - L high cycles. Odd N gives the extra cycle to the high phase.
- Counter cnt (DIV_W bits):
  - Next value = 0 if cnt >= N_eff-1, else cnt+1.
  - The >= compare guarantees wrap when N shrinks below the current cnt.
- o_baud_clk next value = (cnt_next >= L), registered in the same edge as cnt, so the output phase always matches cnt.
- Reset (i_rst=0): cnt=0, o_baud_clk=0, applied immediately without waiting for a clock edge.
- After reset release with N=6:
  - o_baud_clk rises on the 3rd i_clk rising edge.
  - It falls on the 6th edge; period 6, duty 50%, repeating.
- N = 0: cnt and o_baud_clk held at 0 while N stays 0. On a change to non-zero N, counting restarts from cnt=0 on the next edge.
- N change mid-period:
  - The new value applies from the next edge; no shadow register.
  - If cnt >= new N_eff-1, cnt wraps to 0 and o_baud_clk goes low on that edge.
  - Otherwise the period completes using the new N_eff.
- Reset mid-period aborts the period; output is low immediately.
- Counter arithmetic is unsigned DIV_W-bit; cnt never exceeds 2^DIV_W-2, so there is no overflow.

Optional Feature:
- Macro UART_BAUD_TICK_EN.
- When defined: adds output o_baud_tick (1 bit, registered). It is high for exactly one i_clk cycle when cnt_next = 0 with N != 0, i.e. coincident with each falling edge of o_baud_clk. It resets to 0 and is held 0 while N = 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package uart_baud_pkg holds:
  - localparam DIV_W = 16.
  - localparam MIN_DIV = 2.
  - typedef logic [DIV_W-1:0] baud_div_t, used for cfg_div_ratio and cnt.
- No sub-module; counter and output flop fit in one module.

Test Plan:
- Reset check: hold i_rst=0 for 2 cycles with N=6 -> o_baud_clk=0 and cnt=0 throughout. An async assert mid-cycle drops the output before the next edge.
- N=6 steady state: release reset, run 30 cycles -> first rise at edge 3, toggle every 3 edges, period 6, 5 full periods seen.
- N=5 -> low 2, high 3, period 5. N=1 -> identical to N=2: low 1, high 1.
- N=0 -> o_baud_clk stuck 0 for 20 cycles. Then set N=4 -> rise 2 edges later, period 4.
- Shrink mid-period: N=10, at cnt=7 set N=4 -> wrap to 0 on next edge, output low, then period 4. Grow 4->8 at cnt=1 -> current period stretches to 8.
- With UART_BAUD_TICK_EN, N=6 -> o_baud_tick single-cycle pulse every 6 cycles, aligned with each o_baud_clk fall. No pulse while N=0 or in reset.
